// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC measurement controller.
//   state_t      : controller FSM states
//   CODE_W_DEF   : default fine-code width
//   FLAG_*       : bit positions inside res_flags
//   WAIT_GUARD   : cycles allowed in WAIT_CODES for the fine codes to arrive
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARMED      = 3'd1,
    ST_RUN        = 3'd2,
    ST_WAIT_CODES = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam int CODE_W_DEF = 6;

  localparam int FLAGS_W    = 3;
  localparam int FLAG_TMO   = 0;
  localparam int FLAG_MISS  = 1;
  localparam int FLAG_CLAMP = 2;

  localparam int WAIT_GUARD = 4;
  localparam int WAIT_CNT_W = $clog2(WAIT_GUARD);

endpackage

// File: rtl/tdc_interval_calc.sv
// Combinational interval arithmetic for the TDC controller.
//   coarse   in  COARSE_W        : coarse cycle count
//   head     in  CODE_W          : head fine code
//   tail     in  CODE_W          : tail fine code (n-1 convention)
//   interval out COARSE_W+CODE_W : coarse*2**CODE_W + head - (tail+1), clamped at 0
//   clamped  out 1               : the raw interval was negative
module tdc_interval_calc
  import tdc_pkg::*;
#(
  parameter int COARSE_W = 16,
  parameter int CODE_W   = CODE_W_DEF
) (
  input  logic [COARSE_W-1:0]        coarse,
  input  logic [CODE_W-1:0]          head,
  input  logic [CODE_W-1:0]          tail,
  output logic [COARSE_W+CODE_W-1:0] interval,
  output logic                       clamped
);

  localparam int RW = COARSE_W + CODE_W;
  localparam int W  = RW + 1;
  localparam logic signed [W-1:0] ONE = 1;

  logic signed [W-1:0] span;
  logic signed [W-1:0] head_s;
  logic signed [W-1:0] tail_s;
  logic signed [W-1:0] raw;

  // A negative span can only come from a short coarse count with a large
  // tail code; it is reported as zero rather than wrapping.
  function automatic logic [RW-1:0] clamp_nonneg(input logic signed [W-1:0] v);
    if (v < 0) return '0;
    return v[RW-1:0];
  endfunction

  always_comb begin
    span     = $signed({1'b0, coarse, {CODE_W{1'b0}}});
    head_s   = $signed({{(COARSE_W+1){1'b0}}, head});
    tail_s   = $signed({{(COARSE_W+1){1'b0}}, tail});
    raw      = span + head_s - tail_s - ONE;
    interval = clamp_nonneg(raw);
    clamped  = raw[W-1];
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement controller: arms on request, counts coarse cycles between
// start and stop events, collects the head/tail fine codes and presents one
// registered result with a valid/ready handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   arm                 : one-cycle request to arm a measurement
//   start_evt, stop_evt : synchronised start / stop events
//   head_code/head_wrena: head fine code and strobe (RUN or WAIT_CODES)
//   tail_code/tail_wrena: tail fine code and strobe (WAIT_CODES only)
//   res_valid/res_ready : result handshake
//   res_interval        : interval in fine units
//   res_flags           : [0] timeout, [1] code missing, [2] clamped
//   busy                : controller not idle
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int          COARSE_W = 16,
  parameter int          CODE_W   = CODE_W_DEF,
  parameter int unsigned TMO      = 2**COARSE_W-1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       start_evt,
  input  logic                       stop_evt,
  input  logic [CODE_W-1:0]          head_code,
  input  logic                       head_wrena,
  input  logic [CODE_W-1:0]          tail_code,
  input  logic                       tail_wrena,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [COARSE_W+CODE_W-1:0] res_interval,
  output logic [FLAGS_W-1:0]         res_flags,
  output logic                       busy
);

  state_t                      state;
  logic [COARSE_W-1:0]         coarse;
  logic [COARSE_W-1:0]         coarse_nxt;
  logic                        head_got;
  logic                        tail_got;
  logic [CODE_W-1:0]           head_q;
  logic [CODE_W-1:0]           tail_q;
  logic [CODE_W-1:0]           head_eff;
  logic [CODE_W-1:0]           tail_eff;
  logic                        head_have;
  logic                        tail_have;
  logic                        guard_end;
  logic [WAIT_CNT_W-1:0]       wait_cnt;
  logic [COARSE_W+CODE_W-1:0]  calc_interval;
  logic                        calc_clamped;
  logic [FLAGS_W-1:0]          tmo_flags;
  logic [FLAGS_W-1:0]          wait_flags;

  // A code strobed in the current cycle counts as captured, so the result
  // can be registered on that same edge and res_valid rises one cycle later.
  always_comb begin
    coarse_nxt = coarse + 1'b1;
    head_have  = head_got | head_wrena;
    tail_have  = tail_got | tail_wrena;
    head_eff   = head_got ? head_q : (head_wrena ? head_code : '0);
    tail_eff   = tail_got ? tail_q : (tail_wrena ? tail_code : '0);
    guard_end  = (wait_cnt == WAIT_CNT_W'(WAIT_GUARD-1));
    tmo_flags             = '0;
    tmo_flags[FLAG_TMO]   = 1'b1;
    wait_flags            = '0;
    wait_flags[FLAG_MISS] = ~(head_have & tail_have);
    wait_flags[FLAG_CLAMP] = calc_clamped;
  end

  tdc_interval_calc #(
    .COARSE_W (COARSE_W),
    .CODE_W   (CODE_W)
  ) u_calc (
    .coarse   (coarse),
    .head     (head_eff),
    .tail     (tail_eff),
    .interval (calc_interval),
    .clamped  (calc_clamped)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      coarse       <= '0;
      head_got     <= 1'b0;
      tail_got     <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      wait_cnt     <= '0;
      res_valid    <= 1'b0;
      res_interval <= '0;
      res_flags    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (start_evt) begin
            coarse   <= '0;
            head_got <= 1'b0;
            tail_got <= 1'b0;
            wait_cnt <= '0;
            state    <= stop_evt ? ST_WAIT_CODES : ST_RUN;
          end
        end
        ST_RUN: begin
          if (head_wrena && !head_got) begin
            head_got <= 1'b1;
            head_q   <= head_code;
          end
          coarse <= coarse_nxt;
          // The abort count wins over a stop arriving on the same cycle.
          if (coarse_nxt == COARSE_W'(TMO)) begin
            state        <= ST_DONE;
            res_valid    <= 1'b1;
            res_interval <= '0;
            res_flags    <= tmo_flags;
          end else if (stop_evt) begin
            state <= ST_WAIT_CODES;
          end
        end
        ST_WAIT_CODES: begin
          if (head_wrena && !head_got) begin
            head_got <= 1'b1;
            head_q   <= head_code;
          end
          if (tail_wrena && !tail_got) begin
            tail_got <= 1'b1;
            tail_q   <= tail_code;
          end
          wait_cnt <= wait_cnt + 1'b1;
          if ((head_have && tail_have) || guard_end) begin
            state        <= ST_DONE;
            res_valid    <= 1'b1;
            res_interval <= calc_interval;
            res_flags    <= wait_flags;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        start_evt = 1'b0;
  logic        stop_evt = 1'b0;
  logic [5:0]  head_code = '0;
  logic        head_wrena = 1'b0;
  logic [5:0]  tail_code = '0;
  logic        tail_wrena = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [21:0] res_interval;
  logic [2:0]  res_flags;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  tdc_meas_ctrl #(
    .COARSE_W (16),
    .CODE_W   (6),
    .TMO      (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .start_evt    (start_evt),
    .stop_evt     (stop_evt),
    .head_code    (head_code),
    .head_wrena   (head_wrena),
    .tail_code    (tail_code),
    .tail_wrena   (tail_wrena),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_interval (res_interval),
    .res_flags    (res_flags),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interval = N*64 + head - (tail+1); missing codes read as 0.
  function automatic void model(input int n, input bit gh, input int h, input bit gt,
                                input int t, output logic [21:0] ei, output logic [2:0] ef);
    int v;
    v  = n * 64 + (gh ? h : 0) - ((gt ? t : 0) + 1);
    ef = 3'b000;
    ef[1] = !(gh && gt);
    if (v < 0) begin
      ef[2] = 1'b1;
      ei    = '0;
    end else begin
      ei = 22'(v);
    end
  endfunction

  // One full measurement. Stop arrives n cycles after start (n==0: same cycle).
  // With n>0 the head code comes with the stop; with n==0 it comes in the
  // first WAIT_CODES cycle. The tail code comes in the first WAIT_CODES cycle.
  task automatic run_meas(input string tag, input int n, input bit gh, input int h,
                          input bit gt, input int t, input int hold);
    logic [21:0] ei;
    logic [2:0]  ef;
    int          lat;
    model(n, gh, h, gt, t, ei, ef);
    arm = 1'b1; tick(); arm = 1'b0;
    check({tag, "_armed_busy"}, 32'(busy), 32'd1);
    stop_evt = 1'b1; tick(); stop_evt = 1'b0;
    start_evt = 1'b1;
    if (n == 0) stop_evt = 1'b1;
    tick();
    start_evt = 1'b0; stop_evt = 1'b0;
    if (n > 0) begin
      for (int i = 1; i < n; i++) tick();
      stop_evt = 1'b1;
      if (gh) begin head_wrena = 1'b1; head_code = 6'(h); end
      tick();
      stop_evt = 1'b0; head_wrena = 1'b0;
    end
    if (gh) begin
      head_wrena = 1'b1;
      head_code  = (n == 0) ? 6'(h) : 6'($urandom_range(0, 63));
    end
    if (gt) begin tail_wrena = 1'b1; tail_code = 6'(t); end
    lat = (gh && gt) ? 1 : 4;
    tick();
    head_wrena = 1'b0; tail_wrena = 1'b0;
    tail_code = 6'($urandom_range(0, 63));
    for (int i = 1; i < lat; i++) begin
      check({tag, "_early_valid"}, 32'(res_valid), 32'd0);
      tick();
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_interval"}, 32'(res_interval), 32'(ei));
    check({tag, "_flags"}, 32'(res_flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, 32'({res_valid, res_flags, res_interval}), 32'({1'b1, ef, ei}));
    end
    res_ready = 1'b1; arm = 1'b1; tick(); res_ready = 1'b0; arm = 1'b0;
    check({tag, "_hs_idle"}, 32'({busy, res_valid}), 32'd0);
    tick();
    check({tag, "_arm_ignored"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", 32'({busy, res_valid, res_flags, res_interval}), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    start_evt = 1'b1; tick(); start_evt = 1'b0;
    check("start_in_idle_ignored", 32'(busy), 32'd0);

    run_meas("basic",     10, 1'b1, 20, 1'b1, 5,  0);
    run_meas("clamp",      0, 1'b1, 3,  1'b1, 10, 0);
    run_meas("miss_tail",  2, 1'b1, 7,  1'b0, 0,  0);
    run_meas("hold5",      6, 1'b1, 40, 1'b1, 63, 5);
    run_meas("miss_both",  1, 1'b0, 0,  1'b0, 0,  1);

    for (int k = 0; k < 12; k++) begin
      run_meas("rand", int'($urandom_range(0, 40)), ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end

    // Timeout with stray start events and head strobes during RUN.
    arm = 1'b1; tick(); arm = 1'b0;
    start_evt = 1'b1; tick(); start_evt = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 200) begin
      start_evt  = 1'($urandom_range(0, 1));
      head_wrena = 1'($urandom_range(0, 1));
      head_code  = 6'($urandom_range(0, 63));
      tick();
      cnt++;
    end
    start_evt = 1'b0; head_wrena = 1'b0;
    check("tmo_cycles", 32'(cnt), 32'd100);
    check("tmo_interval", 32'(res_interval), 32'd0);
    check("tmo_flags", 32'(res_flags), 32'b001);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check("tmo_hs_idle", 32'(busy), 32'd0);

    // Asynchronous reset while a result is held.
    arm = 1'b1; tick(); arm = 1'b0;
    start_evt = 1'b1; tick(); start_evt = 1'b0;
    tick(); tick();
    stop_evt = 1'b1; tick(); stop_evt = 1'b0;
    head_wrena = 1'b1; head_code = 6'd9; tail_wrena = 1'b1; tail_code = 6'd2;
    tick();
    head_wrena = 1'b0; tail_wrena = 1'b0;
    check("pre_rst_valid", 32'({res_valid, res_interval}), 32'({1'b1, 22'd198}));
    #2 rst = 1'b1;
    #1;
    check("rst_done_async", 32'({busy, res_valid, res_flags, res_interval}), 32'd0);
    tick();
    rst = 1'b0;

    // Asynchronous reset during RUN; later events need a new arm.
    arm = 1'b1; tick(); arm = 1'b0;
    start_evt = 1'b1; tick(); start_evt = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rst_run_async", 32'({busy, res_valid, res_flags, res_interval}), 32'd0);
    tick();
    rst = 1'b0;
    start_evt = 1'b1; tick(); start_evt = 1'b0;
    tick(); tick();
    stop_evt = 1'b1; tick(); stop_evt = 1'b0;
    head_wrena = 1'b1; tail_wrena = 1'b1; tick();
    head_wrena = 1'b0; tail_wrena = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_quiet", 32'({busy, res_valid}), 32'd0);
      tick();
    end

    run_meas("after_rst", 4, 1'b1, 11, 1'b1, 30, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

Interface
REQ-001 SHALL have parameter COARSE_W, default 16, meaning the coarse cycle counter width.
REQ-002 SHALL have parameter CODE_W, default 6, meaning the fine-code width of the head and tail fractional counters.
REQ-003 SHALL have parameter TMO, default 2**COARSE_W-1, meaning the coarse count at which a measurement aborts.
REQ-004 SHALL have port clk  in  1  system clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port arm  in  1  one-cycle request to arm one measurement.
REQ-007 SHALL have port start_evt  in  1  synchronised start event, coarse-counter domain.
REQ-008 SHALL have port stop_evt  in  1  synchronised stop event.
REQ-009 SHALL have ports head_code  in  CODE_W and head_wrena  in  1: head fine code and its write strobe.
REQ-010 SHALL have ports tail_code  in  CODE_W and tail_wrena  in  1: tail fine code (n-1 convention) and its write strobe.
REQ-011 SHALL have port res_valid  out  1  result available.
REQ-012 SHALL have port res_ready  in  1  consumer accepts result.
REQ-013 SHALL have port res_interval  out  COARSE_W+CODE_W  interval in fine units.
REQ-014 SHALL have port res_flags  out  3  [0] timeout, [1] code missing, [2] clamped.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ARMED, RUN, WAIT_CODES, DONE.
REQ-017 IDLE: arm -> ARMED; all other inputs ignored.
REQ-018 ARMED: start_evt -> RUN, coarse <= 0, head/tail capture flags cleared; arm ignored.
REQ-019 RUN: coarse +1 per cycle; a stop_evt N cycles after the start_evt cycle SHALL yield coarse = N; stop_evt -> WAIT_CODES.
REQ-020 RUN: coarse reaching TMO -> DONE with res_flags[0]=1 and res_interval=0.
REQ-021 start_evt and stop_evt in the same cycle in ARMED -> WAIT_CODES with coarse = 0.
REQ-022 head_wrena in RUN or WAIT_CODES SHALL capture head_code (first strobe only); tail_wrena in WAIT_CODES SHALL capture tail_code (first strobe only).
REQ-023 WAIT_CODES -> DONE when both codes are captured, or after 4 cycles with res_flags[1]=1; a missing code is treated as 0.
REQ-024 SHALL compute interval = coarse*2**CODE_W + head - (tail+1) at full width, signed internally.
REQ-025 Negative interval SHALL clamp to 0 and set res_flags[2].
REQ-026 Result and flags SHALL be registered on entry to DONE; res_valid asserts the cycle after the last code is captured.
REQ-027 DONE: res_valid, res_interval and res_flags held stable until res_ready; res_valid&res_ready -> IDLE next cycle; arm in that cycle ignored.
REQ-028 start_evt/stop_evt outside their relevant states SHALL be ignored (no re-trigger).

Reset
REQ-029 rst SHALL force IDLE, coarse=0, capture flags=0, res_valid=0, res_interval=0, res_flags=0, busy=0 immediately, regardless of clk.
REQ-030 Reset mid-measurement SHALL discard the measurement; no res_valid follows until a new arm/start/stop.

Structure
REQ-031 Package tdc_pkg SHALL hold the state enum, CODE_W default, flag bit indices and the WAIT_CODES guard length (4).
REQ-032 Interval arithmetic and clamp SHALL be a combinational sub-module tdc_interval_calc.

Verification
REQ-033 arm; start; stop 10 cycles later; head=20, tail=5 -> res_interval=654, flags=000.
REQ-034 TMO=100, arm, start, no stop -> DONE after 100 cycles, flags=001, interval=0.
REQ-035 coarse=0 (start/stop same cycle), head=3, tail=10 -> interval=0, flags=100.
REQ-036 stop with no tail_wrena, head=7, coarse=2 -> after 4 cycles interval=134, flags=010.
REQ-037 res_ready low 5 cycles -> outputs stable 5 cycles; handshake -> IDLE, busy=0.
REQ-038 rst pulse during RUN -> outputs zero at once; subsequent start_evt ignored until arm.
